// File: rtl/cube_mmio_frontend.sv
// rtl/cube_mmio_frontend.sv - Cube v2 host-side MMIO/wide-data responder
// Decodes control/instruction writes, assembles L0 entries, streams ACC quarters.
module cube_mmio_frontend #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          WIDE_W    = 2048,
  parameter int          IDX_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wvalid,
  input  logic [63:0]           mem_waddr,
  input  logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_raddr,
  input  logic [WIDE_W-1:0]     mem_wdata_wide,
  input  logic                  mem_wdata_wide_valid,
  output logic [63:0]           mem_rdata,
  output logic [WIDE_W-1:0]     mem_rdata_wide,
  output logic                  l0a_wen,
  output logic [IDX_W-1:0]      l0a_widx,
  output logic [2*WIDE_W-1:0]   l0a_wdata,
  output logic                  l0b_wen,
  output logic [IDX_W-1:0]      l0b_widx,
  output logic [2*WIDE_W-1:0]   l0b_wdata,
  output logic                  acc_ren,
  output logic [IDX_W-1:0]      acc_ridx,
  input  logic [4*WIDE_W-1:0]   acc_rdata,
  output logic [15:0]           inst_m,
  output logic [15:0]           inst_k,
  output logic [15:0]           inst_n,
  output logic                  start,
  output logic                  soft_rst,
  input  logic                  core_busy,
  input  logic                  core_done,
  input  logic                  core_qfull,
  input  logic                  core_qempty
);

  localparam logic [63:0] ADDR_CTRL   = BASE_ADDR + 64'h0000;
  localparam logic [63:0] ADDR_STATUS = BASE_ADDR + 64'h0008;
  localparam logic [63:0] ADDR_INST   = BASE_ADDR + 64'h0010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_H0    = 3'd1,
    S_LD_H1    = 3'd2,
    S_ST_FETCH = 3'd3,
    S_ST_Q     = 3'd4,
    S_WR       = 3'd5
  } state_t;

  state_t                state, state_mid, state_nxt;
  logic                  err, inst_valid, tgt_b, fetch_pend;
  logic [1:0]            q;
  logic [IDX_W-1:0]      idx;
  logic [WIDE_W-1:0]     stage, beat1, wide_hold, wide_view;
  logic [4*WIDE_W-1:0]   shadow, view_src;
  logic [2:0]            state_code;

  logic wr_ctrl, wr_inst, do_reset, load_a, load_b, store_acc, cmd_any, cmd_ok;
  logic start_req, start_ok, err_set, beat_h0, beat_h1, ack_adv, ack_last;

  logic unused_wdata_hi;
  assign unused_wdata_hi = &{1'b0, mem_wdata[63:48]};

  // MMIO write is resolved first into state_mid; the wide beat then acts on state_mid.
  always_comb begin
    wr_ctrl   = mem_wvalid && (mem_waddr == ADDR_CTRL);
    wr_inst   = mem_wvalid && (mem_waddr == ADDR_INST);
    do_reset  = wr_ctrl && mem_wdata[1];
    load_a    = wr_ctrl && !mem_wdata[1] && mem_wdata[2];
    load_b    = wr_ctrl && !mem_wdata[1] && !mem_wdata[2] && mem_wdata[3];
    store_acc = wr_ctrl && !mem_wdata[1] && !mem_wdata[2] && !mem_wdata[3] && mem_wdata[4];
    cmd_any   = load_a || load_b || store_acc;
    cmd_ok    = cmd_any && (state == S_IDLE);
    start_req = wr_ctrl && !mem_wdata[1] && mem_wdata[0];
    start_ok  = start_req && inst_valid;

    err_set   = 1'b0;
    beat_h0   = 1'b0;
    beat_h1   = 1'b0;
    ack_adv   = 1'b0;
    ack_last  = 1'b0;
    state_mid = state;

    if (do_reset) begin
      state_mid = S_IDLE;
    end else if (cmd_any) begin
      if (state == S_IDLE) state_mid = (load_a || load_b) ? S_LD_H0 : S_ST_FETCH;
      else                 err_set   = 1'b1;
    end
    if (start_req && !inst_valid) err_set = 1'b1;

    state_nxt = state_mid;
    if (!do_reset) begin
      case (state)
        S_WR:       state_nxt = S_IDLE;
        S_ST_FETCH: state_nxt = S_ST_Q;
        default:    ;
      endcase
    end

    if (mem_wdata_wide_valid && !do_reset) begin
      case (state_mid)
        S_LD_H0: begin
          beat_h0   = 1'b1;
          state_nxt = S_LD_H1;
        end
        S_LD_H1: begin
          beat_h1   = 1'b1;
          state_nxt = S_WR;
        end
        S_ST_Q: begin
          if (q == 2'd3) begin
            ack_last  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ack_adv = 1'b1;
          end
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  // While the fetch is still in flight, show acc_rdata directly so quarter 0 is valid on ST_Q entry.
  always_comb begin
    view_src = fetch_pend ? acc_rdata : shadow;
    case (q)
      2'd0:    wide_view = view_src[0*WIDE_W +: WIDE_W];
      2'd1:    wide_view = view_src[1*WIDE_W +: WIDE_W];
      2'd2:    wide_view = view_src[2*WIDE_W +: WIDE_W];
      default: wide_view = view_src[3*WIDE_W +: WIDE_W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      err        <= 1'b0;
      inst_valid <= 1'b0;
      tgt_b      <= 1'b0;
      fetch_pend <= 1'b0;
      q          <= 2'd0;
      idx        <= '0;
      stage      <= '0;
      beat1      <= '0;
      shadow     <= '0;
      wide_hold  <= '0;
      inst_m     <= '0;
      inst_k     <= '0;
      inst_n     <= '0;
      start      <= 1'b0;
      soft_rst   <= 1'b0;
    end else begin
      state    <= state_nxt;
      soft_rst <= do_reset;
      start    <= start_ok;

      if (do_reset)     err <= 1'b0;
      else if (err_set) err <= 1'b1;

      if (do_reset || start_ok) inst_valid <= 1'b0;
      else if (wr_inst)         inst_valid <= 1'b1;

      if (wr_inst) begin
        inst_m <= mem_wdata[15:0];
        inst_k <= mem_wdata[31:16];
        inst_n <= mem_wdata[47:32];
      end

      if (cmd_ok) begin
        idx   <= mem_wdata[8 +: IDX_W];
        tgt_b <= load_b;
      end

      if (beat_h0) stage <= mem_wdata_wide;
      if (beat_h1) beat1 <= mem_wdata_wide;

      fetch_pend <= (state == S_ST_FETCH) && !do_reset;
      if (fetch_pend) shadow <= acc_rdata;

      if (do_reset || state == S_ST_FETCH || ack_last) q <= 2'd0;
      else if (ack_adv)                                q <= q + 2'd1;

      if (state == S_ST_Q) wide_hold <= wide_view;
    end
  end

  assign state_code     = state;
  assign mem_rdata_wide = (state == S_ST_Q) ? wide_view : wide_hold;

  assign l0a_wen   = (state == S_WR) && !tgt_b;
  assign l0b_wen   = (state == S_WR) && tgt_b;
  assign l0a_widx  = idx;
  assign l0b_widx  = idx;
  assign l0a_wdata = {beat1, stage};
  assign l0b_wdata = {beat1, stage};
  assign acc_ren   = (state == S_ST_FETCH);
  assign acc_ridx  = idx;

  always_comb begin
    mem_rdata = '0;
    if (mem_raddr == ADDR_STATUS)
      mem_rdata = {52'd0, inst_valid, err, q, 1'b0, state_code,
                   core_qempty, core_qfull, core_done, core_busy};
    else if (mem_raddr == ADDR_INST)
      mem_rdata = {16'd0, inst_n, inst_k, inst_m};
  end

endmodule

// File: tb/tb_cube_mmio_frontend.sv
// tb/tb_cube_mmio_frontend.sv - directed table-driven bench for cube_mmio_frontend
// Register-map vectors in a table, multi-cycle load/store/reset sequences by hand.
module tb_cube_mmio_frontend;

  localparam int W = 2048;
  localparam logic [63:0] A_CTRL   = 64'h8000_0000;
  localparam logic [63:0] A_STATUS = 64'h8000_0008;
  localparam logic [63:0] A_INST   = 64'h8000_0010;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_wvalid;
  logic [63:0]     mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [W-1:0]    mem_wdata_wide, mem_rdata_wide;
  logic            mem_wdata_wide_valid;
  logic            l0a_wen, l0b_wen, acc_ren, start, soft_rst;
  logic [6:0]      l0a_widx, l0b_widx, acc_ridx;
  logic [2*W-1:0]  l0a_wdata, l0b_wdata;
  logic [4*W-1:0]  acc_rdata;
  logic [15:0]     inst_m, inst_k, inst_n;
  logic            core_busy, core_done, core_qfull, core_qempty;

  cube_mmio_frontend dut (
    .clk(clk), .rst(rst),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_wdata_wide(mem_wdata_wide),
    .mem_wdata_wide_valid(mem_wdata_wide_valid),
    .mem_rdata(mem_rdata), .mem_rdata_wide(mem_rdata_wide),
    .l0a_wen(l0a_wen), .l0a_widx(l0a_widx), .l0a_wdata(l0a_wdata),
    .l0b_wen(l0b_wen), .l0b_widx(l0b_widx), .l0b_wdata(l0b_wdata),
    .acc_ren(acc_ren), .acc_ridx(acc_ridx), .acc_rdata(acc_rdata),
    .inst_m(inst_m), .inst_k(inst_k), .inst_n(inst_n),
    .start(start), .soft_rst(soft_rst),
    .core_busy(core_busy), .core_done(core_done),
    .core_qfull(core_qfull), .core_qempty(core_qempty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt_a = 0, cnt_b = 0, cnt_start = 0, cnt_soft = 0, cnt_ren = 0;

  always @(negedge clk) begin
    if (l0a_wen)  cnt_a     <= cnt_a + 1;
    if (l0b_wen)  cnt_b     <= cnt_b + 1;
    if (start)    cnt_start <= cnt_start + 1;
    if (soft_rst) cnt_soft  <= cnt_soft + 1;
    if (acc_ren)  cnt_ren   <= cnt_ren + 1;
  end

  typedef struct {
    logic        wv;
    logic [63:0] wa;
    logic [63:0] wd;
    logic [63:0] ra;
    logic [3:0]  core;
    logic [63:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [63:0] a, input logic [63:0] d);
    mem_wvalid = 1'b1;
    mem_waddr  = a;
    mem_wdata  = d;
    tick();
    mem_wvalid = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d);
    mem_wdata_wide_valid = 1'b1;
    mem_wdata_wide       = d;
    tick();
    mem_wdata_wide_valid = 1'b0;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_wide(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %h want low64 %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic read_status(output logic [63:0] v);
    mem_raddr = A_STATUS;
    #1;
    v = mem_rdata;
  endtask

  vec_t          vecs[11];
  logic [63:0]   st;
  logic [W-1:0]  b0, b1, qexp;
  int            base_a, base_b, base_s, base_soft, base_r;

  initial begin
    vecs[0]  = '{1'b0, 64'h0, 64'h0, A_STATUS, 4'b0001, 64'h1};
    vecs[1]  = '{1'b0, 64'h0, 64'h0, 64'h8000_4000, 4'b0001, 64'h0};
    vecs[2]  = '{1'b1, A_INST, 64'h0000_0010_0010_0010, A_INST, 4'b0000, 64'h0000_0010_0010_0010};
    vecs[3]  = '{1'b0, 64'h0, 64'h0, A_STATUS, 4'b1000, 64'h808};
    vecs[4]  = '{1'b1, A_INST, 64'h1234_0003_0002_0001, A_INST, 4'b0000, 64'h0000_0003_0002_0001};
    vecs[5]  = '{1'b1, 64'h8000_0018, '1, A_INST, 4'b0000, 64'h0000_0003_0002_0001};
    vecs[6]  = '{1'b1, 64'h1_8000_0010, '1, A_INST, 4'b0000, 64'h0000_0003_0002_0001};
    vecs[7]  = '{1'b1, A_CTRL, 64'h2, A_STATUS, 4'b0110, 64'h6};
    vecs[8]  = '{1'b0, 64'h0, 64'h0, 64'h8000_000C, 4'b1111, 64'h0};
    vecs[9]  = '{1'b1, A_CTRL, 64'h1, A_STATUS, 4'b0000, 64'h400};
    vecs[10] = '{1'b1, A_CTRL, 64'h2, A_STATUS, 4'b0000, 64'h0};

    for (int i = 0; i < W/16; i++) begin
      b0[i*16 +: 16] = 16'(i);
      b1[i*16 +: 16] = 16'(128 + i);
    end

    rst = 1'b1;
    mem_wvalid = 1'b0; mem_waddr = '0; mem_wdata = '0; mem_raddr = '0;
    mem_wdata_wide = '0; mem_wdata_wide_valid = 1'b0; acc_rdata = '0;
    {core_qempty, core_qfull, core_done, core_busy} = 4'b0000;
    tick(); tick();
    rst = 1'b0;

    read_status(st);
    check("reset_status", st, 64'h0);
    check("reset_l0a_wen", 64'(l0a_wen), 64'h0);
    check("reset_start", 64'(start), 64'h0);
    check("reset_acc_ren", 64'(acc_ren), 64'h0);
    check("reset_rdata_wide", mem_rdata_wide[63:0], 64'h0);

    // register map vectors
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wv) mmio_wr(vecs[i].wa, vecs[i].wd);
      else            tick();
      mem_raddr = vecs[i].ra;
      {core_qempty, core_qfull, core_done, core_busy} = vecs[i].core;
      #1;
      check($sformatf("vec%0d", i), mem_rdata, vecs[i].exp);
    end
    {core_qempty, core_qfull, core_done, core_busy} = 4'b0000;

    // L0A load, index 0
    base_a = cnt_a; base_b = cnt_b;
    mmio_wr(A_CTRL, 64'h4);
    read_status(st);
    check("lda_state_h0", 64'(st[6:4]), 64'h1);
    beat(b0);
    beat(b1);
    check("lda_wen", 64'(l0a_wen), 64'h1);
    check("lda_widx", 64'(l0a_widx), 64'h0);
    check("lda_lo16", 64'(l0a_wdata[15:0]), 64'h0);
    check("lda_hi16", 64'(l0a_wdata[4095:4080]), 64'd255);
    check_wide("lda_data", l0a_wdata, {b1, b0});
    tick();
    read_status(st);
    check("lda_state_idle", 64'(st[6:4]), 64'h0);
    check("lda_count", 64'(cnt_a - base_a), 64'h1);
    check("lda_no_l0b", 64'(cnt_b - base_b), 64'h0);

    // L0B load idx 5 aborted by RESET between the beats
    base_b = cnt_b; base_soft = cnt_soft;
    mmio_wr(A_CTRL, 64'h508);
    beat(b0);
    mmio_wr(A_CTRL, 64'h2);
    check("rst_soft_pulse", 64'(soft_rst), 64'h1);
    tick(); tick(); tick();
    read_status(st);
    check("rst_status", st, 64'h0);
    check("rst_no_l0b", 64'(cnt_b - base_b), 64'h0);
    check("rst_soft_count", 64'(cnt_soft - base_soft), 64'h1);

    // MATMUL + START, then START without new instruction
    base_s = cnt_start;
    mmio_wr(A_INST, 64'h0000_0010_0010_0010);
    check("inst_mkn", {16'd0, inst_n, inst_k, inst_m}, 64'h0000_0010_0010_0010);
    mmio_wr(A_CTRL, 64'h1);
    check("start_pulse", 64'(start), 64'h1);
    tick();
    check("start_low", 64'(start), 64'h0);
    read_status(st);
    check("start_iv_clr", 64'(st[11:10]), 64'h0);
    mmio_wr(A_CTRL, 64'h1);
    tick();
    check("start_count", 64'(cnt_start - base_s), 64'h1);
    read_status(st);
    check("start2_err", 64'(st[10]), 64'h1);
    mmio_wr(A_CTRL, 64'h2);
    tick();

    // STORE_ACC idx 3, quarter q holds q+1
    base_r = cnt_ren;
    acc_rdata = '0;
    for (int k = 0; k < 4; k++) acc_rdata[k*W +: 32] = 32'(k + 1);
    mmio_wr(A_CTRL, 64'h310);
    check("st_ren", 64'(acc_ren), 64'h1);
    check("st_ridx", 64'(acc_ridx), 64'h3);
    tick();
    for (int qi = 0; qi < 4; qi++) begin
      qexp = '0;
      qexp[31:0] = 32'(qi + 1);
      check_wide($sformatf("st_q%0d", qi), {{W{1'b0}}, mem_rdata_wide}, {{W{1'b0}}, qexp});
      beat('0);
      if (qi == 0) acc_rdata = '1;
    end
    read_status(st);
    check("st_idle", 64'(st[9:4]), 64'h0);
    check("st_hold", mem_rdata_wide[63:0], 64'h4);
    check("st_ren_count", 64'(cnt_ren - base_r), 64'h1);

    // LOAD_L0B while in LD_H1 is dropped, L0A entry completes
    base_a = cnt_a; base_b = cnt_b;
    mmio_wr(A_CTRL, 64'h204);
    beat(b1);
    mmio_wr(A_CTRL, 64'h8);
    beat(b0);
    check("busy_wen", 64'(l0a_wen), 64'h1);
    check("busy_widx", 64'(l0a_widx), 64'h2);
    check_wide("busy_data", l0a_wdata, {b0, b1});
    tick();
    read_status(st);
    check("busy_err_idle", 64'(st[10:4]), 64'h40);
    check("busy_counts", 64'({cnt_a - base_a, cnt_b - base_b}), {32'd1, 32'd0});

    // rst in the middle of a load
    base_a = cnt_a;
    mmio_wr(A_CTRL, 64'h4);
    beat(b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    read_status(st);
    check("midrst_status", st, 64'h0);
    check("midrst_no_wen", 64'(cnt_a - base_a), 64'h0);
    check("midrst_wide", mem_rdata_wide[63:0], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
